// File: rtl/lif_neuron_if.sv
// Bundle of the neuron's data-side signals: enable, pre-synaptic spike and weight in;
// fire pulse, membrane potential, refractory flag and spike counter out.
interface lif_neuron_if #(
    parameter int W_WIDTH = 8,
    parameter int V_WIDTH = 12
);
    logic               en;
    logic               pre_spike;
    logic [W_WIDTH-1:0] weight;
    logic               post_spike;
    logic [V_WIDTH-1:0] membrane;
    logic               refractory;
    logic [7:0]         spike_count;

    modport master (
        output en, pre_spike, weight,
        input  post_spike, membrane, refractory, spike_count
    );

    modport slave (
        input  en, pre_spike, weight,
        output post_spike, membrane, refractory, spike_count
    );
endinterface

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: saturating membrane with periodic shift leak,
// one-cycle fire pulse, then a fixed refractory window.
module lif_neuron #(
    parameter int W_WIDTH       = 8,
    parameter int V_WIDTH       = 12,
    parameter int THRESHOLD     = 200,
    parameter int LEAK_SHIFT    = 3,
    parameter int LEAK_PERIOD   = 4,
    parameter int REFRAC_CYCLES = 8
) (
    input  logic         clk,
    input  logic         rst,
    lif_neuron_if.slave  bus
);
    localparam int VW1  = V_WIDTH + 1;
    localparam int LC_W = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
    localparam int RC_W = (REFRAC_CYCLES > 1) ? $clog2(REFRAC_CYCLES) : 1;
    localparam logic [LC_W-1:0]    LC_LAST = LC_W'(LEAK_PERIOD - 1);
    localparam logic [RC_W-1:0]    RC_INIT = RC_W'((REFRAC_CYCLES > 0) ? REFRAC_CYCLES - 1 : 0);
    localparam logic [V_WIDTH-1:0] THR     = V_WIDTH'(THRESHOLD);

    typedef enum logic [1:0] {S_INTEGRATE, S_FIRE, S_REFRAC} state_t;

    state_t              r_state, w_state_nxt;
    logic [V_WIDTH-1:0]  r_v, w_v_nxt;
    logic                r_post, w_post_nxt;
    logic                r_refr, w_refr_nxt;
    logic [7:0]          r_cnt, w_cnt_nxt;
    logic [LC_W-1:0]     r_lc, w_lc_nxt;
    logic [RC_W-1:0]     r_rc, w_rc_nxt;

    logic [VW1-1:0]      w_leak;
    logic [VW1-1:0]      w_add;
    logic [VW1-1:0]      w_raw;
    logic [V_WIDTH-1:0]  w_vsum;

    // The extra top bit of the raw sum flags overflow past the membrane range.
    function automatic logic [V_WIDTH-1:0] clamp_v(input logic [VW1-1:0] x);
        return x[V_WIDTH] ? {V_WIDTH{1'b1}} : x[V_WIDTH-1:0];
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] x);
        return (x == 8'hFF) ? x : x + 8'd1;
    endfunction

    // Leak is taken from the pre-add membrane, so it never exceeds r_v.
    assign w_leak = (r_lc == LC_LAST) ? VW1'(r_v >> LEAK_SHIFT) : '0;
    assign w_add  = bus.pre_spike ? VW1'(bus.weight) : '0;
    assign w_raw  = VW1'(r_v) - w_leak + w_add;
    assign w_vsum = clamp_v(w_raw);

    always_comb begin
        w_state_nxt = r_state;
        w_v_nxt     = r_v;
        w_post_nxt  = 1'b0;
        w_refr_nxt  = r_refr;
        w_cnt_nxt   = r_cnt;
        w_lc_nxt    = r_lc;
        w_rc_nxt    = r_rc;
        case (r_state)
            S_INTEGRATE: begin
                if (bus.en) begin
                    w_lc_nxt = (r_lc == LC_LAST) ? '0 : r_lc + LC_W'(1);
                    if (w_vsum >= THR) begin
                        w_v_nxt     = '0;
                        w_post_nxt  = 1'b1;
                        w_cnt_nxt   = sat_inc8(r_cnt);
                        w_lc_nxt    = '0;
                        w_state_nxt = S_FIRE;
                    end else begin
                        w_v_nxt = w_vsum;
                    end
                end
            end
            S_FIRE: begin
                w_v_nxt = '0;
                if (REFRAC_CYCLES == 0) begin
                    w_state_nxt = S_INTEGRATE;
                end else begin
                    w_state_nxt = S_REFRAC;
                    w_rc_nxt    = RC_INIT;
                    w_refr_nxt  = 1'b1;
                end
            end
            S_REFRAC: begin
                w_v_nxt = '0;
                if (r_rc == '0) begin
                    w_state_nxt = S_INTEGRATE;
                    w_refr_nxt  = 1'b0;
                end else begin
                    w_rc_nxt = r_rc - RC_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_INTEGRATE;
                w_v_nxt     = '0;
                w_refr_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_INTEGRATE;
            r_v     <= '0;
            r_post  <= 1'b0;
            r_refr  <= 1'b0;
            r_cnt   <= '0;
            r_lc    <= '0;
            r_rc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_v     <= w_v_nxt;
            r_post  <= w_post_nxt;
            r_refr  <= w_refr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_lc    <= w_lc_nxt;
            r_rc    <= w_rc_nxt;
        end
    end

    assign bus.post_spike  = r_post;
    assign bus.membrane    = r_v;
    assign bus.refractory  = r_refr;
    assign bus.spike_count = r_cnt;
endmodule

// File: tb/tb_lif_neuron.sv
// Bench for lif_neuron: a default instance and a THRESHOLD=4095/REFRAC_CYCLES=0 instance
// share one stimulus stream and are compared every cycle against an arithmetic model.
module tb_lif_neuron;
    logic       clk = 1'b0;
    logic       rst;
    logic       t_en;
    logic       t_pre;
    logic [7:0] t_w;

    always #5 clk = ~clk;

    lif_neuron_if #(.W_WIDTH(8), .V_WIDTH(12)) bus0 ();
    lif_neuron_if #(.W_WIDTH(8), .V_WIDTH(12)) bus1 ();

    assign bus0.en = t_en;
    assign bus0.pre_spike = t_pre;
    assign bus0.weight = t_w;
    assign bus1.en = t_en;
    assign bus1.pre_spike = t_pre;
    assign bus1.weight = t_w;

    lif_neuron dut0 (.clk(clk), .rst(rst), .bus(bus0));
    lif_neuron #(.THRESHOLD(4095), .REFRAC_CYCLES(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // Reference model: plain integers, one entry per instance.
    localparam int LP = 4;
    localparam int LS = 3;
    localparam int VMAX = 4095;
    int m_th[2] = '{200, 4095};
    int m_rc[2] = '{8, 0};
    int m_v[2];
    int m_phase[2];
    int m_rleft[2];
    int m_cnt[2];
    int m_post[2];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_v[i] = 0; m_phase[i] = 0; m_rleft[i] = 0; m_cnt[i] = 0; m_post[i] = 0;
        end
    endtask

    task automatic model_step();
        int leak;
        int nv;
        for (int i = 0; i < 2; i++) begin
            if (m_post[i] != 0) begin
                m_post[i] = 0;
                m_v[i] = 0;
                m_rleft[i] = m_rc[i];
            end else if (m_rleft[i] > 0) begin
                m_rleft[i] = m_rleft[i] - 1;
            end else if (t_en) begin
                leak = (m_phase[i] == LP - 1) ? (m_v[i] / (1 << LS)) : 0;
                m_phase[i] = (m_phase[i] + 1) % LP;
                nv = m_v[i] - leak + (t_pre ? int'(t_w) : 0);
                if (nv > VMAX) nv = VMAX;
                if (nv >= m_th[i]) begin
                    m_v[i] = 0;
                    m_post[i] = 1;
                    m_cnt[i] = (m_cnt[i] < 255) ? m_cnt[i] + 1 : 255;
                    m_phase[i] = 0;
                end else begin
                    m_v[i] = nv;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("d0.post", bus0.post_spike, m_post[0]);
        chk("d0.mem", bus0.membrane, m_v[0]);
        chk("d0.refr", bus0.refractory, (m_rleft[0] > 0));
        chk("d0.cnt", bus0.spike_count, m_cnt[0]);
        chk("d1.post", bus1.post_spike, m_post[1]);
        chk("d1.mem", bus1.membrane, m_v[1]);
        chk("d1.refr", bus1.refractory, (m_rleft[1] > 0));
        chk("d1.cnt", bus1.spike_count, m_cnt[1]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    // Called just after a tick: raise rst mid-cycle, check the asynchronous clear, release at negedge.
    task automatic do_async_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int idx;
        int last_mem;
        rst = 1'b1;
        t_en = 1'b0; t_pre = 1'b0; t_w = 8'd0;
        model_reset();
        #3;
        compare_all();
        @(negedge clk);
        rst = 1'b0;

        // Test 1: run, then asynchronous reset mid-cycle
        t_en = 1'b1; t_w = 8'd100;
        for (int k = 0; k < 20; k++) begin
            t_pre = 1'($urandom_range(0, 1));
            tick();
        end
        do_async_reset();
        chk("t1.mem_rst", bus0.membrane, 0);
        chk("t1.post_rst", bus0.post_spike, 0);
        t_pre = 1'b0;
        tick();
        chk("t1.mem_after", bus0.membrane, 0);

        // Test 2: two 100-weight spikes fire, refractory for 8 cycles
        do_async_reset();
        t_en = 1'b1; t_w = 8'd100; t_pre = 1'b1;
        tick();
        chk("t2.mem100", bus0.membrane, 100);
        tick();
        chk("t2.post", bus0.post_spike, 1);
        chk("t2.mem0", bus0.membrane, 0);
        t_pre = 1'b0;
        n = 0;
        repeat (12) begin
            tick();
            if (bus0.refractory) n++;
        end
        chk("t2.refr_len", n, 8);
        chk("t2.count", bus0.spike_count, 1);

        // Test 3: leak schedule with an en=0 pause
        do_async_reset();
        t_en = 1'b1; t_w = 8'd64; t_pre = 1'b1;
        tick();
        chk("t3.c0", bus0.membrane, 64);
        t_pre = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k == 3) chk("t3.c3", bus0.membrane, 56);
            if (k == 7) chk("t3.c7", bus0.membrane, 49);
            if (k == 11) chk("t3.c11", bus0.membrane, 43);
            if (k == 5) begin
                t_en = 1'b0;
                t_pre = 1'b1;
                repeat (5) begin
                    tick();
                    chk("t3.frozen", bus0.membrane, 56);
                end
                t_pre = 1'b0;
                t_en = 1'b1;
            end
        end
        chk("t3.nofire", bus0.spike_count, 0);

        // Test 4: input ignored during refractory, first integrate cycle fires
        do_async_reset();
        t_en = 1'b1; t_w = 8'd255; t_pre = 1'b1;
        tick();
        chk("t4.fire1", bus0.post_spike, 1);
        idx = -1;
        for (int k = 1; k <= 20 && idx < 0; k++) begin
            tick();
            if (bus0.post_spike) idx = k;
            else chk("t4.mem_held", bus0.membrane, 0);
        end
        chk("t4.gap", idx, 10);

        // Test 5: clamp at 4095 fires the high-threshold instance; no refractory after it
        do_async_reset();
        t_en = 1'b1; t_w = 8'd255; t_pre = 1'b1;
        idx = -1; last_mem = 0;
        for (int k = 0; k < 100 && idx < 0; k++) begin
            tick();
            if (bus1.post_spike) idx = k;
            else last_mem = int'(bus1.membrane);
        end
        chk("t5.fire_tick", idx, 21);
        chk("t5.pre_fire_mem", last_mem, 3859);
        tick();
        chk("t5.fire_refr", bus1.refractory, 0);
        chk("t5.fire_mem", bus1.membrane, 0);
        tick();
        chk("t5.reint_mem", bus1.membrane, 255);
        chk("t5.reint_refr", bus1.refractory, 0);

        // Randomised mix with occasional asynchronous resets
        for (int k = 0; k < 3000; k++) begin
            t_en = ($urandom_range(0, 3) != 0);
            t_pre = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: t_w = 8'd0;
                1: t_w = 8'd255;
                2: t_w = 8'($urandom_range(190, 210));
                default: t_w = 8'($urandom_range(0, 120));
            endcase
            tick();
            if ($urandom_range(0, 299) == 0) do_async_reset();
        end

        // Test 6: spike counter saturation and reset during refractory
        do_async_reset();
        t_en = 1'b1; t_w = 8'd255; t_pre = 1'b1;
        repeat (2620) tick();
        chk("t6.sat", bus0.spike_count, 255);
        idx = -1;
        for (int k = 0; k < 20 && idx < 0; k++) begin
            tick();
            if (bus0.refractory) idx = k;
        end
        chk("t6.in_refr", (idx >= 0), 1);
        do_async_reset();
        chk("t6.refr_clr", bus0.refractory, 0);
        t_en = 1'b0; t_pre = 1'b0;
        tick();
        chk("t6.idle_refr", bus0.refractory, 0);
        chk("t6.idle_mem", bus0.membrane, 0);
        t_en = 1'b1; t_pre = 1'b1;
        tick();
        chk("t6.integrate", bus0.post_spike, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
